// File: rtl/multicycle_controller.sv
// Multicycle sequencer: walks each instruction through fetch/decode/execute/memory/writeback,
// owns the NZCV flags and condition evaluation, and drives every datapath select and enable.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] RD,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [3:0] ALUControl,
   output logic [3:0] State,
   output logic       Undef
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   state_t     state, next_state;
   logic [3:0] flags;
   logic       cond_ex_reg;
   logic       cond_ex;
   logic [3:0] alu_op;
   logic       no_write;
   logic       upd_nz, upd_cv, is_cmp;
   logic       pc_w, reg_w, mem_w, ir_w;
   logic       is_exec;

   always_comb begin
      cond_ex = 1'b0;
      case (Cond)
         4'b0000: cond_ex = flags[2];
         4'b0001: cond_ex = ~flags[2];
         4'b0010: cond_ex = flags[1];
         4'b0011: cond_ex = ~flags[1];
         4'b0100: cond_ex = flags[3];
         4'b0101: cond_ex = ~flags[3];
         4'b0110: cond_ex = flags[0];
         4'b0111: cond_ex = ~flags[0];
         4'b1000: cond_ex = flags[1] & ~flags[2];
         4'b1001: cond_ex = ~flags[1] | flags[2];
         4'b1010: cond_ex = (flags[3] == flags[0]);
         4'b1011: cond_ex = (flags[3] != flags[0]);
         4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
         4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Unrecognised commands compute ADD but neither write back nor touch the flags.
   always_comb begin
      alu_op   = 4'b0000;
      no_write = 1'b0;
      upd_nz   = 1'b1;
      upd_cv   = 1'b0;
      is_cmp   = 1'b0;
      case (Funct[4:1])
         4'b0100: upd_cv = 1'b1;
         4'b0010: begin alu_op = 4'b0001; upd_cv = 1'b1; end
         4'b0000: alu_op = 4'b0010;
         4'b1100: alu_op = 4'b0011;
         4'b1010: begin alu_op = 4'b0001; upd_cv = 1'b1; no_write = 1'b1; is_cmp = 1'b1; end
         default: begin no_write = 1'b1; upd_nz = 1'b0; end
      endcase
   end

   always_comb begin
      pc_w       = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      ir_w       = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = 4'b0000;
      Undef      = 1'b0;
      next_state = S_FETCH;
      case (state)
         S_FETCH: begin
            ir_w = 1'b1; pc_w = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            next_state = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            case (Op)
               2'b01:   next_state = S_MEMADR;
               2'b00:   next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b10:   next_state = S_BRANCH;
               default: begin Undef = 1'b1; next_state = S_FETCH; end
            endcase
         end
         S_MEMADR: begin
            ALUSrcB = 2'b01;
            next_state = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin AdrSrc = 1'b1; next_state = S_MEMWB; end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            if (RD == 4'hF) pc_w = cond_ex_reg;
            else            reg_w = cond_ex_reg;
         end
         S_MEMWRITE: begin AdrSrc = 1'b1; mem_w = cond_ex_reg; end
         S_EXECUTER: begin ALUControl = alu_op; next_state = S_ALUWB; end
         S_EXECUTEI: begin ALUSrcB = 2'b01; ALUControl = alu_op; next_state = S_ALUWB; end
         S_ALUWB: begin
            if (!no_write) begin
               if (RD == 4'hF) pc_w = cond_ex_reg;
               else            reg_w = cond_ex_reg;
            end
         end
         S_BRANCH: begin
            ALUSrcB = 2'b01; ResultSrc = 2'b10; pc_w = cond_ex_reg;
         end
         default: next_state = S_FETCH;
      endcase
   end

   assign is_exec = (state == S_EXECUTER) || (state == S_EXECUTEI);

   // Condition is frozen at decode, so a flag-setting op's own writeback uses the old flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_FETCH;
         flags       <= 4'b0000;
         cond_ex_reg <= 1'b0;
      end else begin
         state <= next_state;
         if (state == S_DECODE) cond_ex_reg <= cond_ex;
         if (is_exec && cond_ex_reg && (Funct[0] || is_cmp)) begin
            if (upd_nz) flags[3:2] <= ALUFlags[3:2];
            if (upd_cv) flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

   assign PCWrite  = pc_w & ~reset;
   assign RegWrite = reg_w & ~reset;
   assign MemWrite = mem_w & ~reset;
   assign IRWrite  = ir_w & ~reset;
   assign ImmSrc   = Op;
   assign RegSrc   = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};
   assign State    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model predicts every cycle's outputs,
// a compare process checks them, and directed cases pin the model with literal sequences.
module tb_multicycle_controller;
   localparam int W = 23;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond, RD, ALUFlags;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, Undef;
   logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
   logic [3:0] ALUControl, State;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .RD(RD),
      .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
      .State(State), .Undef(Undef)
   );

   always #5 clk = ~clk;

   logic [W-1:0] exp_q[$];
   logic [3:0]   obs_state[$];
   logic [3:0]   obs_en[$];
   logic         obs_undef[$];
   int           n_chk = 0;
   int           n_pass = 0;
   logic [3:0]   mflags = 4'b0000;
   logic         m_cx = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, r;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cf;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cf & ~z;
         3'd5: r = (n == v);
         3'd6: r = ~z & (n == v);
         default: r = 1'b1;
      endcase
      return r ^ c[0];
   endfunction

   // 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 CMP, 5 other
   function automatic int kind(input logic [3:0] cmd);
      case (cmd)
         4'b0100: return 0;
         4'b0010: return 1;
         4'b0000: return 2;
         4'b1100: return 3;
         4'b1010: return 4;
         default: return 5;
      endcase
   endfunction

   function automatic logic [W-1:0] exp_vec(input int st, input logic [1:0] op, input logic [5:0] f,
                                            input logic [3:0] rd, input logic cx, input logic rst);
      logic pcw, regw, memw, irw, adr, srca, und;
      logic [1:0] srcb, res;
      logic [3:0] aluc;
      int k;
      logic [3:0] ctl_tab[6];
      ctl_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd1, 4'd0};
      k = kind(f[4:1]);
      {pcw, regw, memw, irw, adr, srca, und} = '0;
      srcb = 2'b00; res = 2'b00; aluc = 4'b0000;
      case (st)
         0: begin irw = 1; pcw = 1; srca = 1; srcb = 2'b10; res = 2'b10; end
         1: begin srca = 1; srcb = 2'b10; res = 2'b10; und = (op == 2'b11); end
         2: srcb = 2'b01;
         3: adr = 1;
         4: begin res = 2'b01; if (rd == 4'hF) pcw = cx; else regw = cx; end
         5: begin adr = 1; memw = cx; end
         6: aluc = ctl_tab[k];
         7: begin srcb = 2'b01; aluc = ctl_tab[k]; end
         8: if (k < 4) begin if (rd == 4'hF) pcw = cx; else regw = cx; end
         default: begin srcb = 2'b01; res = 2'b10; pcw = cx; end
      endcase
      if (rst) {pcw, regw, memw, irw} = 4'b0000;
      return {pcw, regw, memw, irw, adr, srca, srcb, res, op,
              (op == 2'b01) & ~f[0], (op == 2'b10), aluc, 4'(st), und};
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e, a;
         e = exp_q.pop_front();
         a = {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
              ImmSrc, RegSrc, ALUControl, State, Undef};
         check($sformatf("cycle state=%0d", e[4:1]), 32'(a), 32'(e));
         obs_state.push_back(State);
         obs_en.push_back({PCWrite, RegWrite, MemWrite, IRWrite});
         obs_undef.push_back(Undef);
      end
   end

   task automatic clear_logs();
      obs_state.delete();
      obs_en.delete();
      obs_undef.delete();
   endtask

   // Entered just after a rising edge with the DUT in FETCH; leaves it likewise.
   task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                            input logic [3:0] rd, input logic [4:0] fx, input bit rst_mid);
      int st[5];
      int n;
      int k;
      st = '{0, 1, 0, 0, 0};
      n = 2;
      case (op)
         2'b01: begin st[2] = 2; st[3] = f[0] ? 3 : 5; st[4] = 4; n = f[0] ? 5 : 4; end
         2'b00: begin st[2] = f[5] ? 7 : 6; st[3] = 8; n = 4; end
         2'b10: begin st[2] = 9; n = 3; end
         default: n = 2;
      endcase
      for (int i = 0; i < n; i++) begin
         Cond = c; Op = op; Funct = f; RD = rd;
         ALUFlags = 4'($urandom_range(0, 15));
         if ((st[i] == 6 || st[i] == 7) && fx[4]) ALUFlags = fx[3:0];
         if (rst_mid && st[i] == 2) begin
            reset = 1'b1;
            exp_q.push_back(exp_vec(st[i], op, f, rd, m_cx, 1'b1));
            mflags = 4'b0000;
            m_cx = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            return;
         end
         exp_q.push_back(exp_vec(st[i], op, f, rd, m_cx, 1'b0));
         if (st[i] == 1) m_cx = cond_holds(c, mflags);
         if (st[i] == 6 || st[i] == 7) begin
            k = kind(f[4:1]);
            if (m_cx && (k == 4 || (f[0] && k < 4))) begin
               mflags[3:2] = ALUFlags[3:2];
               if (k < 2 || k == 4) mflags[1:0] = ALUFlags[1:0];
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [5:0] f;
      logic [3:0] cmd_pool[5];
      cmd_pool = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
      reset = 1'b1; Cond = 4'h0; Op = 2'b00; Funct = 6'h00; RD = 4'h0; ALUFlags = 4'h0;
      @(posedge clk); #1;
      exp_q.push_back(exp_vec(0, 2'b00, 6'h00, 4'h0, 1'b0, 1'b1));
      @(posedge clk); #1;
      reset = 1'b0;

      clear_logs();
      run_instr(4'hE, 2'b00, 6'b101000, 4'h3, 5'b0, 0);
      check("addi_states", {obs_state[0], obs_state[1], obs_state[2], obs_state[3]}, 32'h0178);
      check("addi_enables", {obs_en[0], obs_en[1], obs_en[2], obs_en[3]}, 32'h9004);

      run_instr(4'hE, 2'b00, 6'b010101, 4'h0, 5'b1_0100, 0);
      clear_logs();
      run_instr(4'h0, 2'b00, 6'b001000, 4'h1, 5'b0, 0);
      check("addeq_z1_wb", 32'(obs_en[3]), 32'h4);
      run_instr(4'hE, 2'b00, 6'b010101, 4'h0, 5'b1_0000, 0);
      clear_logs();
      run_instr(4'h0, 2'b00, 6'b001000, 4'h1, 5'b0, 0);
      check("addeq_z0_wb", 32'(obs_en[3]), 32'h0);

      clear_logs();
      run_instr(4'hE, 2'b01, 6'b000001, 4'h2, 5'b0, 0);
      check("ldr_states", {obs_state[0], obs_state[1], obs_state[2], obs_state[3], obs_state[4]}, 32'h01234);
      check("ldr_enables", {obs_en[0], obs_en[1], obs_en[2], obs_en[3], obs_en[4]}, 32'h90004);
      clear_logs();
      run_instr(4'hE, 2'b01, 6'b000000, 4'h2, 5'b0, 0);
      check("str_states", {obs_state[0], obs_state[1], obs_state[2], obs_state[3]}, 32'h0125);
      check("str_enables", {obs_en[0], obs_en[1], obs_en[2], obs_en[3]}, 32'h9002);

      run_instr(4'hE, 2'b00, 6'b010101, 4'h0, 5'b1_0100, 0);
      clear_logs();
      run_instr(4'h1, 2'b10, 6'b000000, 4'h0, 5'b0, 0);
      check("bne_z1_states", {obs_state[0], obs_state[1], obs_state[2]}, 32'h019);
      check("bne_z1_enables", {obs_en[0], obs_en[1], obs_en[2]}, 32'h900);
      run_instr(4'hE, 2'b00, 6'b010101, 4'h0, 5'b1_0000, 0);
      clear_logs();
      run_instr(4'h1, 2'b10, 6'b000000, 4'h0, 5'b0, 0);
      check("bne_z0_enables", {obs_en[0], obs_en[1], obs_en[2]}, 32'h908);

      run_instr(4'hE, 2'b00, 6'b001001, 4'h4, 5'b1_0110, 0);
      run_instr(4'hE, 2'b00, 6'b011001, 4'h4, 5'b1_1001, 0);
      clear_logs();
      run_instr(4'h2, 2'b00, 6'b001000, 4'h5, 5'b0, 0);
      check("addcs_after_orrs", 32'(obs_en[3]), 32'h4);
      clear_logs();
      run_instr(4'hA, 2'b00, 6'b001000, 4'h5, 5'b0, 0);
      check("addge_after_orrs", 32'(obs_en[3]), 32'h0);
      clear_logs();
      run_instr(4'hE, 2'b00, 6'b101000, 4'hF, 5'b0, 0);
      check("rd15_wb", 32'(obs_en[3]), 32'h8);

      clear_logs();
      run_instr(4'hE, 2'b11, 6'b000000, 4'h0, 5'b0, 0);
      check("undef_states", {obs_state[0], obs_state[1]}, 32'h01);
      check("undef_pulse", {31'b0, obs_undef[1]}, 32'h1);

      run_instr(4'hE, 2'b00, 6'b010101, 4'h0, 5'b1_0100, 0);
      clear_logs();
      run_instr(4'hE, 2'b01, 6'b000001, 4'h2, 5'b0, 1);
      run_instr(4'h0, 2'b10, 6'b000000, 4'h0, 5'b0, 0);
      check("reset_mid_states", {obs_state[0], obs_state[1], obs_state[2], obs_state[3],
                                 obs_state[4], obs_state[5]}, 32'h012019);
      check("reset_mid_enables", 32'(obs_en[2]), 32'h0);
      check("beq_after_reset", 32'(obs_en[5]), 32'h0);

      for (int i = 0; i < 300; i++) begin
         f = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 5) != 0) f[4:1] = cmd_pool[$urandom_range(0, 4)];
         run_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), f,
                   ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14)), 5'b0, 0);
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
